// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM arbiter: FSM encoding,
// RAM size codes, the hold-register layout and the alignment rule.
package ram_arbiter_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned UBHW_W = 3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic [UBHW_W-1:0] UBHW_BYTE   = 3'b000;
  localparam logic [UBHW_W-1:0] UBHW_HALF   = 3'b001;
  localparam logic [UBHW_W-1:0] UBHW_WORD   = 3'b010;
  localparam logic [UBHW_W-1:0] UBHW_BYTE_U = 3'b100;
  localparam logic [UBHW_W-1:0] UBHW_HALF_U = 3'b101;

  localparam logic [XLEN-1:0] SIM_UART_ADDR = 32'h1000_0000;

  typedef struct packed {
    logic              is_d;
    logic              we;
    logic              err;
    logic [UBHW_W-1:0] ubhw;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
  } hold_t;

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic misaligned(input logic [UBHW_W-1:0] ubhw, input logic [1:0] a);
    if (ubhw[1]) return (a != 2'b00);
    if (ubhw[0]) return a[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/ram_prio_sel.sv
// Combinational grant decision: data port first unless the waiting
// instruction port has been passed over STARVE_MAX times in a row.
module ram_prio_sel
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             i_idle,
  input  logic             i_ireq,
  input  logic             i_dreq,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_igrant,
  output logic             o_dgrant
);

  logic w_starved;

  assign w_starved = i_ireq && (i_starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    o_igrant = 1'b0;
    o_dgrant = 1'b0;
    if (i_idle) begin
      if (i_dreq && !w_starved) o_dgrant = 1'b1;
      else if (i_ireq)          o_igrant = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-ported RAM.
// One request per two cycles: grant in IDLE, drive RAM in ACCESS, respond next.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clka,
  input  logic        rstn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_ubhw,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic [2:0]  ram_ubhw,
  input  logic [31:0] ram_dout
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  hold_t            r_hold;
  hold_t            w_hold_nxt;
  logic             w_idle;
  logic             w_i_gnt;
  logic             w_d_gnt;
  logic             r_i_rvalid;
  logic             r_d_rvalid;
  logic             r_d_err;
  logic [31:0]      r_i_rdata;
  logic [31:0]      r_d_rdata;

  // Grants are suppressed while reset is asserted.
  assign w_idle = (r_state == ST_IDLE) && rstn;

  ram_prio_sel #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_prio_sel (
    .i_idle       (w_idle),
    .i_ireq       (i_req),
    .i_dreq       (d_req),
    .i_starve_cnt (r_cnt),
    .o_igrant     (w_i_gnt),
    .o_dgrant     (w_d_gnt)
  );

  assign i_gnt    = w_i_gnt;
  assign d_gnt    = w_d_gnt;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;
  assign d_err    = r_d_err;

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_i_gnt || w_d_gnt) w_state_nxt = ST_ACCESS;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the winner's request so the requester may move on after gnt.
  always_comb begin
    w_hold_nxt = r_hold;
    if (w_d_gnt) begin
      w_hold_nxt.is_d  = 1'b1;
      w_hold_nxt.we    = d_we;
      w_hold_nxt.err   = misaligned(d_ubhw, d_addr[1:0]);
      w_hold_nxt.ubhw  = d_ubhw;
      w_hold_nxt.addr  = d_addr;
      w_hold_nxt.wdata = d_wdata;
    end else if (w_i_gnt) begin
      w_hold_nxt.is_d  = 1'b0;
      w_hold_nxt.we    = 1'b0;
      w_hold_nxt.err   = 1'b0;
      w_hold_nxt.ubhw  = UBHW_WORD;
      w_hold_nxt.addr  = i_addr;
      w_hold_nxt.wdata = '0;
    end
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) r_hold <= '0;
    else       r_hold <= w_hold_nxt;
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn)                 r_cnt <= '0;
    else if (!i_req || w_i_gnt) r_cnt <= '0;
    else if (w_d_gnt && (r_cnt != CNT_W'(STARVE_MAX))) r_cnt <= r_cnt + CNT_W'(1);
  end

  // RAM is only driven during ACCESS; misaligned accesses never write.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    ram_ubhw = '0;
    if (r_state == ST_ACCESS) begin
      ram_addr = r_hold.addr;
      ram_din  = r_hold.wdata;
      ram_we   = r_hold.we && !r_hold.err;
      ram_ubhw = r_hold.ubhw;
    end
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_d_err    <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      if (r_state == ST_ACCESS) begin
        if (r_hold.is_d) begin
          r_d_rvalid <= 1'b1;
          r_d_err    <= r_hold.err;
          r_d_rdata  <= (r_hold.we || r_hold.err) ? '0 : ram_dout;
        end else begin
          r_i_rvalid <= 1'b1;
          r_i_rdata  <= ram_dout;
        end
      end
    end
  end

endmodule
